mcpu_fetch_unit: RTL and testbench
==================================

Name: mcpu_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the MCPU RAM controller's instruction port. It owns the program counter, drives instraddr, and samples the combinational instrrd. Fetched bytes go into a small prefetch FIFO, which presents them to the decoder over a valid/ready handshake. Supports start, halt-with-drain and jump redirect with flush.

Parameters:
WORD_SIZE, 8, instruction/data word width
ADDR_WIDTH, 8, PC / instruction address width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin fetching from current PC (honoured in IDLE only)
halt  in  1  stop fetching, drain FIFO, return to IDLE
redirect_valid  in  1  jump request; flush FIFO, load PC
redirect_addr  in  ADDR_WIDTH  jump target
instraddr  out  ADDR_WIDTH  address to RAM controller instruction port (= PC register)
instrrd  in  WORD_SIZE  instruction word from RAM controller (combinational, same cycle)
instr_out  out  WORD_SIZE  FIFO head instruction
instr_pc  out  ADDR_WIDTH  address the head instruction was fetched from
instr_valid  out  1  FIFO non-empty
instr_ready  in  1  decoder accepts head this cycle
busy  out  1  state != IDLE
fifo_count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, FIFO empty (rd/wr ptr=0, count=0). Outputs: instraddr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, busy=0, fifo_count=0. Reset mid-operation discards all FIFO contents immediately.
- States: IDLE, FETCH, DRAIN.
- IDLE: no pushes. start=1 -> FETCH. redirect_valid=1 loads PC, stays IDLE. halt is ignored.
- FETCH: push = (count<DEPTH) or pop. On push, write {instrrd, PC} at wr ptr and PC<=PC+1 mod 2^ADDR_WIDTH (0xFF->0x00 wraps, no flag). Full and no pop: PC holds, instrrd is not sampled. halt=1 -> DRAIN, and no push that cycle. start is ignored.
- DRAIN: no pushes. Pops continue. Transition to IDLE on the edge where count becomes 0 (or is already 0). PC holds, so a later start resumes at the next unfetched address.
- Pop: pop = instr_valid & instr_ready. Head advances; instr_out/instr_pc show the new head next cycle. Simultaneous push and pop when full is legal; count is unchanged.
- Redirect has priority over push/halt/start in every state.
  - The current-cycle pop still completes: the head is counted as transferred.
  - All remaining entries are flushed (count=0 next cycle).
  - The instrrd sampled that cycle is discarded.
  - PC<=redirect_addr.
  - Next state: FETCH if in FETCH and halt=0; otherwise IDLE.
  - First push from the target occurs at the end of the next FETCH cycle.
- Latency:
  - start sampled at edge E0 -> FETCH after E0, first push at E1, instr_valid=1 after E1.
  - redirect at edge R0 -> instr_valid=0 after R0, target instruction valid after R1.
- Throughput: 1 instruction/cycle sustained with instr_ready held high.
- instr_valid is independent of instr_ready (no combinational path ready->valid).
- fifo_count is always equal to pushes minus pops minus flushed entries, and never exceeds DEPTH.

Decomposition:
- Shared package mcpu_pkg: WORD_SIZE, ADDR_WIDTH defaults, and the fetch-state enum (FS_IDLE, FS_FETCH, FS_DRAIN).
- One natural sub-module, mcpu_prefetch_fifo: a parameterised synchronous FIFO with a (WORD_SIZE+ADDR_WIDTH)-bit entry, push/pop/flush, count, and extra wrap bit on pointers.
- mcpu_fetch_unit holds the PC, the state machine and the redirect/halt priority logic.

Test Plan:
1. Reset, RAM preloaded mem[i]=i^8'hA5, start pulse, instr_ready=1 -> instr_out sequence A5,A4,A7,... with instr_pc 0,1,2,...; instr_valid first high 2 edges after start; one instruction per cycle.
2. Backpressure: instr_ready=0 for 10 cycles after start -> fifo_count saturates at 4, instraddr holds at 4. Then instr_ready=1 -> instr_pc 0..7 delivered in order, no gaps or duplicates.
3. Redirect: while fetching at PC=5 with 3 entries queued, pulse redirect_valid with redirect_addr=0x40 and instr_ready=1 -> head (pc 2) counted delivered, pcs 3,4 never appear; next valid instr_pc=0x40 one cycle later.
4. Halt/drain: halt with count=3, instr_ready=1 -> 3 more instructions, busy drops when empty, instraddr frozen. Re-start resumes at the next sequential pc with no gaps.
5. Wrap: redirect to 0xFE, run 4 instructions -> instr_pc FE, FF, 00, 01.
6. Async reset asserted mid-FETCH with full FIFO -> instr_valid=0, fifo_count=0, instraddr=RESET_PC immediately, without waiting for a clock edge; no output activity until the next start.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: default datapath widths and the fetch-stage state encoding.
package mcpu_pkg;

    localparam int unsigned WORD_SIZE  = 8;
    localparam int unsigned ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mcpu_prefetch_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush; pointers carry an extra wrap bit
// so occupancy is simply the pointer difference.
module mcpu_prefetch_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push_c, do_pop_c;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == PW'(DEPTH));
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/mcpu_fetch_unit.sv
// MCPU instruction-fetch stage: owns the PC, fetches from the RAM instruction port
// into a prefetch FIFO, and handles start, halt-with-drain and redirect-with-flush.
module mcpu_fetch_unit
    import mcpu_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = mcpu_pkg::WORD_SIZE,
    parameter int unsigned ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_addr,
    output logic [ADDR_WIDTH-1:0]    instraddr,
    input  logic [WORD_SIZE-1:0]     instrrd,
    output logic [WORD_SIZE-1:0]     instr_out,
    output logic [ADDR_WIDTH-1:0]    instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = WORD_SIZE + ADDR_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  push_c, pop_c, flush_c;
    logic                  fifo_empty, fifo_full;
    logic [CNT_W-1:0]      count;
    logic [ENT_W-1:0]      head;

    assign pop_c = ~fifo_empty & instr_ready;

    // Next state / PC; redirect overrides everything except the in-flight pop.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push_c  = 1'b0;
        flush_c = 1'b0;

        case (state_q)
            FS_IDLE: begin
                if (start) state_d = FS_FETCH;
            end
            FS_FETCH: begin
                if (halt) state_d = FS_DRAIN;
                else      push_c  = ~fifo_full | pop_c;
            end
            FS_DRAIN: begin
                if (count == '0 || (count == CNT_W'(1) && pop_c)) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase

        if (push_c) pc_d = pc_q + ADDR_WIDTH'(1);

        if (redirect_valid) begin
            flush_c = 1'b1;
            push_c  = 1'b0;
            pc_d    = redirect_addr;
            state_d = (state_q == FS_FETCH && !halt) ? FS_FETCH : FS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= ADDR_WIDTH'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    mcpu_prefetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush_c),
        .wdata ({instrrd, pc_q}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign instraddr   = pc_q;
    assign instr_out   = head[ENT_W-1 -: WORD_SIZE];
    assign instr_pc    = head[ADDR_WIDTH-1:0];
    assign instr_valid = ~fifo_empty;
    assign busy        = (state_q != FS_IDLE);
    assign fifo_count  = count;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Self-checking bench for mcpu_fetch_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_mcpu_fetch_unit;

    localparam int unsigned AW       = 8;
    localparam int unsigned WS       = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = 3;
    localparam int unsigned RESET_PC = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic [AW-1:0] instraddr, instr_pc;
    logic [WS-1:0] instrrd, instr_out;
    logic          instr_valid, busy;
    logic [CW-1:0] fifo_count;
    logic [WS-1:0] ram [256];

    assign instrrd = ram[instraddr];

    always #5 clk = ~clk;

    mcpu_fetch_unit #(
        .WORD_SIZE  (WS),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instraddr      (instraddr),
        .instrrd        (instrrd),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .busy           (busy),
        .fifo_count     (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as queues, PC and an operating mode.
    int unsigned m_pc;
    int          m_mode;          // 0 idle, 1 fetching, 2 draining
    int unsigned q_pc[$];
    int unsigned q_ins[$];
    int unsigned deliv[$];

    function automatic logic [31:0] dv(input int i);
        return (deliv.size() > i) ? 32'(deliv[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_mode = 0;
        q_pc.delete();
        q_ins.delete();
    endtask

    task automatic check_outputs();
        check_eq("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
        check_eq("fifo_count", 32'(fifo_count), 32'(q_pc.size()));
        check_eq("instraddr", 32'(instraddr), m_pc);
        check_eq("busy", 32'(busy), 32'(m_mode != 0));
        if (q_pc.size() != 0) begin
            check_eq("instr_pc", 32'(instr_pc), q_pc[0]);
            check_eq("instr_out", 32'(instr_out), q_ins[0]);
        end
    endtask

    task automatic model_edge();
        bit pop;
        int sz;
        sz  = q_pc.size();
        pop = (sz != 0) && instr_ready;
        if (redirect_valid) begin
            q_pc.delete();
            q_ins.delete();
            m_pc   = 32'(redirect_addr);
            m_mode = (m_mode == 1 && !halt) ? 1 : 0;
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    if (halt) m_mode = 2;
                    else if (sz < DEPTH || pop) begin
                        q_pc.push_back(m_pc);
                        q_ins.push_back(32'(ram[8'(m_pc)]));
                        m_pc = (m_pc + 1) % 256;
                    end
                end
                default: if (q_pc.size() == 0) m_mode = 0;
            endcase
        end
    endtask

    task automatic step();
        if (instr_valid && instr_ready) deliv.push_back(32'(instr_pc));
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit st, input bit hl, input bit rv, input int unsigned ra, input bit rdy);
        start          = st;
        halt           = hl;
        redirect_valid = rv;
        redirect_addr  = 8'(ra);
        instr_ready    = rdy;
        step();
    endtask

    // Assert reset mid-cycle and check that outputs clear before any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_addr", 32'(instraddr), RESET_PC);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_instr_out", 32'(instr_out), 32'd0);
        check_eq("rst_instr_pc", 32'(instr_pc), 32'd0);
        model_reset();
        deliv.delete();
        start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetch at full throughput.
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1);
        check_eq("t1_count", 32'(deliv.size()), 32'd6);
        for (int i = 0; i < 4; i++) check_eq("t1_pc", dv(i), 32'(i));

        // Backpressure saturates the FIFO, then in-order delivery.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        check_eq("t2_full", 32'(fifo_count), 32'd4);
        check_eq("t2_addr", 32'(instraddr), 32'd4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) check_eq("t2_order", dv(i), 32'(i));

        // Redirect with three entries queued at PC=5.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check_eq("t3_pre_count", 32'(fifo_count), 32'd3);
        check_eq("t3_pre_addr", 32'(instraddr), 32'd5);
        cyc(0, 0, 1, 32'h40, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check_eq("t3_head", dv(2), 32'd2);
        check_eq("t3_target", dv(3), 32'h40);
        check_eq("t3_next", dv(4), 32'h41);

        // Halt with three queued, drain, then resume.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        check_eq("t4_drained", 32'(deliv.size()), 32'd3);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_addr", 32'(instraddr), 32'd3);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        check_eq("t4_resume", dv(3), 32'd3);

        // PC wrap-around.
        do_reset();
        cyc(0, 0, 1, 32'hFE, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        check_eq("t5_fe", dv(0), 32'hFE);
        check_eq("t5_ff", dv(1), 32'hFF);
        check_eq("t5_00", dv(2), 32'h00);
        check_eq("t5_01", dv(3), 32'h01);

        // Async reset with a full FIFO, then quiet until the next start.
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        check_eq("t6_full", 32'(fifo_count), 32'd4);
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, $urandom_range(0, 1) == 1, 0, 0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 255),
                $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
